// File: rtl/fifo_rd_packer.sv
// Packs PACK FIFO entries (LSB lane first) into one word; the word loads one clock after its last entry returns.
// Stalls popping when the output slot and the assembly register are both full; flush emits a partial word marked m_last.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last,
    output logic                       busy
);
    localparam int              CW     = $clog2(PACK + 1) + 1;
    localparam int              AW     = DATA_WIDTH * PACK;
    localparam logic [CW-1:0]   PACK_C = CW'(PACK);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_inflight;
    logic              r_flush_pend;
    logic [AW-1:0]     r_asm;
    logic [AW-1:0]     r_data;
    logic [PACK-1:0]   r_keep;
    logic              r_valid;
    logic              r_last;

    logic              w_slot_free;
    logic              w_rd_en;
    logic              w_land_full;
    logic              w_flush_now;
    logic [CW-1:0]     w_sum;
    logic [AW-1:0]     w_asm_next;
    logic [AW-1:0]     w_part_data;
    logic [PACK-1:0]   w_part_keep;

    assign w_slot_free = !r_valid || m_ready;
    assign w_sum       = r_cnt + CW'(r_inflight);
    // Window closes once the returning entry would fill the last free lane.
    assign w_rd_en     = rst && !fifo_empty && !r_flush_pend && (r_state == S_FILL) && (w_sum < PACK_C);
    assign w_land_full = r_inflight && (w_sum == PACK_C);
    assign w_flush_now = r_flush_pend || flush;

    always_comb begin
        w_asm_next  = r_asm;
        w_part_data = '0;
        w_part_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (r_inflight && (r_cnt == CW'(i))) begin
                w_asm_next[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
            end
            if (CW'(i) < r_cnt) begin
                w_part_keep[i]                          = 1'b1;
                w_part_data[i*DATA_WIDTH +: DATA_WIDTH] = r_asm[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_FILL;
            r_cnt        <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_asm        <= '0;
            r_data       <= '0;
            r_keep       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_asm      <= w_asm_next;
            r_cnt      <= w_sum;
            if (flush) begin
                r_flush_pend <= 1'b1;
            end
            if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_FILL: begin
                    if (w_land_full) begin
                        if (w_slot_free) begin
                            // A pending flush is satisfied by this full word.
                            r_valid      <= 1'b1;
                            r_data       <= w_asm_next;
                            r_keep       <= '1;
                            r_last       <= w_flush_now;
                            r_cnt        <= '0;
                            r_flush_pend <= 1'b0;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (r_flush_pend && !r_inflight) begin
                        if (r_cnt == '0) begin
                            r_flush_pend <= 1'b0;
                        end else begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_slot_free) begin
                        r_valid      <= 1'b1;
                        r_data       <= r_asm;
                        r_keep       <= '1;
                        r_last       <= w_flush_now;
                        r_cnt        <= '0;
                        r_flush_pend <= 1'b0;
                        r_state      <= S_FILL;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_flush_pend <= 1'b0;
                        r_state      <= S_FILL;
                    end else if (w_slot_free) begin
                        r_valid      <= 1'b1;
                        r_data       <= w_part_data;
                        r_keep       <= w_part_keep;
                        r_last       <= 1'b1;
                        r_cnt        <= '0;
                        r_flush_pend <= 1'b0;
                        r_state      <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = r_valid;
    assign m_data     = r_data;
    assign m_keep     = r_keep;
    assign m_last     = r_last;
    assign busy       = (r_cnt != '0) || r_inflight || r_flush_pend || (r_state != S_FILL);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model with registered read, vector table, corner sequences, randomized byte-stream model.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        busy;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    typedef struct {
        int          n;
        bit          fl;
        logic [7:0]  base;
        logic [31:0] d;
        logic [3:0]  k;
        bit          l;
        int          words;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [0:4095];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pop_cnt = 0;
    int         nlast = 0;
    bit         empty_force = 1'b0;
    word_t      oq[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] out_bytes[$];

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr) || empty_force;

    // FIFO read port: data appears the cycle after the pop.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[11:0]];
            rd_ptr    <= rd_ptr + 1;
            pop_cnt   <= pop_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[11:0]] = b;
        exp_bytes.push_back(b);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_words(input int n, input int budget);
        int t;
        t = 0;
        while (oq.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (oq.size() < n) chk("timeout_words", 64'(oq.size()), 64'(n));
    endtask

    task automatic check_word(input string nm, input int idx, input logic [31:0] d,
                              input logic [3:0] k, input logic l);
        if (oq.size() > idx) begin
            chk({nm, "_data"}, 64'(oq[idx].d), 64'(d));
            chk({nm, "_keep"}, 64'(oq[idx].k), 64'(k));
            chk({nm, "_last"}, 64'(oq[idx].l), 64'(l));
        end else begin
            chk({nm, "_missing"}, 64'(oq.size()), 64'(idx + 1));
        end
    endtask

    // Observer: collects accepted words and checks word-level invariants.
    always @(negedge clk) begin
        if (rst) begin
            if (fifo_rd_en) chk("pop_while_empty", 64'(fifo_empty), 64'd0);
            if (m_valid && m_ready) begin
                oq.push_back({m_data, m_keep, m_last});
                chk("keep_contiguous",
                    64'(((m_keep & (m_keep + 4'd1)) == 4'd0) && (m_keep != 4'd0)), 64'd1);
                if (!m_last) chk("keep_full_unless_last", 64'(m_keep), 64'hF);
                else nlast++;
                for (int i = 0; i < PK; i++) begin
                    if (m_keep[i]) out_bytes.push_back(m_data[i*8 +: 8]);
                    else chk("unused_lane_zero", 64'(m_data[i*8 +: 8]), 64'd0);
                end
            end
        end
    end

    initial begin
        vec_t        vt[8];
        logic [31:0] w;
        int          p0;
        int          nfl;
        int          pushed;

        vt[0] = '{4, 1'b0, 8'h11, 32'h14131211, 4'hF, 1'b0, 1};
        vt[1] = '{3, 1'b1, 8'hA1, 32'h00A3A2A1, 4'h7, 1'b1, 1};
        vt[2] = '{1, 1'b1, 8'h5A, 32'h0000005A, 4'h1, 1'b1, 1};
        vt[3] = '{2, 1'b1, 8'h30, 32'h00003130, 4'h3, 1'b1, 1};
        vt[4] = '{5, 1'b1, 8'h40, 32'h43424140, 4'hF, 1'b0, 2};
        vt[5] = '{0, 1'b1, 8'h00, 32'h00000000, 4'h0, 1'b0, 0};
        vt[6] = '{8, 1'b0, 8'h60, 32'h63626160, 4'hF, 1'b0, 2};
        vt[7] = '{7, 1'b1, 8'h70, 32'h73727170, 4'hF, 1'b0, 2};

        rst     = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;

        // Reset holds everything quiet even with a non-empty FIFO.
        for (int i = 1; i <= 8; i++) push(8'(i * 17));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
        end
        chk("m_valid_rst", 64'(m_valid), 64'd0);
        chk("m_data_rst", 64'(m_data), 64'd0);
        chk("m_keep_rst", 64'(m_keep), 64'd0);
        chk("m_last_rst", 64'(m_last), 64'd0);
        chk("busy_rst", 64'(busy), 64'd0);

        // Streaming: 4 pops per 5 clocks.
        m_ready = 1'b1;
        oq.delete();
        p0  = pop_cnt;
        rst = 1'b1;
        repeat (5) tick();
        chk("pops_in_5", 64'(pop_cnt - p0), 64'd4);
        repeat (5) tick();
        chk("pops_in_10", 64'(pop_cnt - p0), 64'd8);
        wait_words(2, 20);
        check_word("stream_w0", 0, 32'h44332211, 4'hF, 1'b0);
        check_word("stream_w1", 1, 32'h88776655, 4'hF, 1'b0);

        // Reset in the middle of a word drops the two assembled lanes.
        oq.delete();
        push(8'hE1);
        push(8'hE2);
        repeat (6) tick();
        chk("midword_busy", 64'(busy), 64'd1);
        chk("midword_no_valid", 64'(m_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("midword_rst_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h21 + i));
        wait_words(1, 20);
        check_word("after_rst", 0, 32'h24232221, 4'hF, 1'b0);

        // Backpressure: one word in the slot, one in assembly, then pops stop.
        m_ready = 1'b0;
        oq.delete();
        p0 = pop_cnt;
        for (int i = 0; i < 12; i++) push(8'(8'h31 + i));
        repeat (30) tick();
        chk("bp_pops", 64'(pop_cnt - p0), 64'd8);
        chk("bp_valid", 64'(m_valid), 64'd1);
        chk("bp_data", 64'(m_data), 64'h34333231);
        chk("bp_busy", 64'(busy), 64'd1);
        repeat (10) tick();
        chk("bp_data_hold", 64'(m_data), 64'h34333231);
        chk("bp_pops_hold", 64'(pop_cnt - p0), 64'd8);
        m_ready = 1'b1;
        wait_words(3, 40);
        check_word("bp_w0", 0, 32'h34333231, 4'hF, 1'b0);
        check_word("bp_w1", 1, 32'h38373635, 4'hF, 1'b0);
        check_word("bp_w2", 2, 32'h3C3B3A39, 4'hF, 1'b0);

        // Vector table: n entries, optional flush once they have settled.
        for (int v = 0; v < 8; v++) begin
            oq.delete();
            for (int i = 0; i < vt[v].n; i++) push(8'(vt[v].base + 8'(i)));
            repeat (15) tick();
            if (vt[v].fl) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            repeat (15) tick();
            chk($sformatf("vec%0d_words", v), 64'(oq.size()), 64'(vt[v].words));
            if (vt[v].words > 0) check_word($sformatf("vec%0d", v), 0, vt[v].d, vt[v].k, vt[v].l);
            chk($sformatf("vec%0d_idle", v), 64'(busy), 64'd0);
        end

        // Flush with nothing held: busy for one clock, no word.
        oq.delete();
        flush = 1'b1;
        tick();
        chk("idle_flush_busy_set", 64'(busy), 64'd1);
        flush = 1'b0;
        tick();
        chk("idle_flush_busy_drop", 64'(busy), 64'd0);
        repeat (5) tick();
        chk("idle_flush_no_word", 64'(oq.size()), 64'd0);

        // Flush in the same cycle as the pop: in-flight byte is included.
        oq.delete();
        push(8'h5A);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_words(1, 20);
        check_word("flush_with_pop", 0, 32'h0000005A, 4'h1, 1'b1);
        chk("busy_after_accept", 64'(busy), 64'd0);

        // Empty gating, then a flickering empty flag.
        oq.delete();
        empty_force = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) push(8'(8'h91 + i));
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("gated_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        chk("gated_pops", 64'(pop_cnt - p0), 64'd0);
        chk("gated_words", 64'(oq.size()), 64'd0);
        chk("gated_valid", 64'(m_valid), 64'd0);
        for (int c = 0; c < 40; c++) begin
            empty_force = ~empty_force;
            tick();
        end
        empty_force = 1'b0;
        wait_words(2, 30);
        check_word("toggle_w0", 0, 32'h94939291, 4'hF, 1'b0);
        check_word("toggle_w1", 1, 32'h98979695, 4'hF, 1'b0);

        // Random, no flush: output is the pushed stream in groups of PACK.
        exp_bytes.delete();
        out_bytes.delete();
        oq.delete();
        pushed = 0;
        for (int c = 0; c < 2000; c++) begin
            if (pushed < 200 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                pushed++;
            end
            m_ready     = ($urandom_range(0, 3) != 0);
            empty_force = ($urandom_range(0, 4) == 0);
            tick();
        end
        empty_force = 1'b0;
        m_ready     = 1'b1;
        wait_words(50, 100);
        chk("rand_word_count", 64'(oq.size()), 64'd50);
        for (int i = 0; i < 50; i++) begin
            w = {exp_bytes[4*i+3], exp_bytes[4*i+2], exp_bytes[4*i+1], exp_bytes[4*i]};
            check_word($sformatf("rand_w%0d", i), i, w, 4'hF, 1'b0);
        end

        // Random with flushes: every pushed byte comes out once, in order.
        exp_bytes.delete();
        out_bytes.delete();
        oq.delete();
        nlast  = 0;
        nfl    = 0;
        pushed = 0;
        for (int c = 0; c < 1500; c++) begin
            if (pushed < 600 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                pushed++;
            end
            flush = ($urandom_range(0, 15) == 0);
            if (flush) nfl++;
            m_ready     = ($urandom_range(0, 3) != 0);
            empty_force = ($urandom_range(0, 4) == 0);
            tick();
        end
        flush       = 1'b0;
        empty_force = 1'b0;
        m_ready     = 1'b1;
        repeat (30) tick();
        flush = 1'b1;
        nfl++;
        tick();
        flush = 1'b0;
        repeat (30) tick();
        chk("rand2_idle", 64'(busy), 64'd0);
        chk("rand2_byte_count", 64'(out_bytes.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < out_bytes.size(); i++) begin
            chk($sformatf("rand2_byte%0d", i), 64'(out_bytes[i]), 64'(exp_bytes[i]));
        end
        chk("rand2_last_le_flushes", 64'(nlast <= nfl), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
